rrp_mac_pipe: RTL and testbench

Pipelined signed high-radix multiply-accumulate unit with valid/ready flow control. It is the next generation of the fixed-latency high-radix multiplier. Pipeline depth is set by a parameter. Operations can be plain multiply or accumulate, selected per transaction. Accumulator guard digits and a sticky overflow flag are parameterised. It sits between operand producers (online adders or digit-serial front ends) and downstream result consumers that may stall.

---
 rtl/rRp_pkg.sv | 17 +
 rtl/rRp_mac_acc.sv | 46 ++++
 rtl/rrp_mac_pipe.sv | 61 ++++++
 tb/tb_rrp_mac_pipe.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rRp_pkg.sv
// rRp_pkg: width helpers and stage tag record shared by the high-radix MAC pipeline
package rRp_pkg;
  function automatic int digit_bits(input int radix);
    return $clog2(radix) + 1;
  endfunction
  function automatic int prod_bits(input int width, input int d);
    return d * (2 * width + 1);
  endfunction
  function automatic int acc_bits(input int width, input int d, input int guard);
    return prod_bits(width, d) + d * guard;
  endfunction
  typedef struct packed {
    logic valid;
    logic mode;
    logic acc_clr;
  } tag_t;
endpackage

// File: rtl/rRp_mac_acc.sv
// rRp_mac_acc: retire stage - accumulator, sticky overflow flag and output register
module rRp_mac_acc
  import rRp_pkg::*;
#(
  parameter int PW = 27,
  parameter int AW = 33
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv_i,
  input  tag_t          tag_i,
  input  logic [PW-1:0] prod_i,
  output logic          valid_o,
  output logic [AW-1:0] p_o,
  output logic          ovf_o
);
  logic [AW-1:0] acc_q, acc_d, p_q, p_d, ext, sum;
  logic          valid_q, ovf_q, ovf_d, wrap;
  assign ext = AW'($signed(prod_i));
  assign sum = (tag_i.acc_clr ? '0 : acc_q) + ext;
  // a clear-and-add starts from zero, so it can never overflow
  assign wrap = tag_i.mode && !tag_i.acc_clr && acc_q[AW-1] == ext[AW-1] && sum[AW-1] != acc_q[AW-1];
  always_comb begin
    acc_d = tag_i.mode ? sum : tag_i.acc_clr ? '0 : acc_q;
    p_d   = tag_i.mode ? sum : ext;
    ovf_d = !tag_i.acc_clr && (ovf_q || wrap);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      acc_q   <= '0;
      p_q     <= '0;
      ovf_q   <= 1'b0;
    end else if (adv_i) begin
      valid_q <= tag_i.valid;
      if (tag_i.valid) begin
        acc_q <= acc_d;
        p_q   <= p_d;
        ovf_q <= ovf_d;
      end
    end
  end
  assign valid_o = valid_q;
  assign p_o     = p_q;
  assign ovf_o   = ovf_q;
endmodule

// File: rtl/rrp_mac_pipe.sv
// rrp_mac_pipe: pipelined signed high-radix multiply-accumulate with valid/ready flow control
module rrp_mac_pipe
  import rRp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int RADIX = 4,
  parameter int DEPTH = 6,
  parameter int GUARD = 2,
  localparam int D  = digit_bits(RADIX),
  localparam int PW = prod_bits(WIDTH, D),
  localparam int AW = acc_bits(WIDTH, D, GUARD)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [D*WIDTH-1:0] x_in,
  input  logic [D*WIDTH-1:0] y_in,
  input  logic              mode,
  input  logic              acc_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AW-1:0]     p_out,
  output logic              ovf
);
  typedef struct packed {
    tag_t          tag;
    logic [PW-1:0] prod;
  } stage_t;
  tag_t                  cap_q;
  logic [D*WIDTH-1:0]    x_q, y_q;
  stage_t [DEPTH-1:0]    pipe_q;
  logic [PW-1:0]         prod;
  logic                  adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign prod     = PW'($signed(x_q)) * PW'($signed(y_q));
  // operands are captured first; stage 1 then registers the full product
  always_ff @(posedge clock) begin
    if (reset) begin
      cap_q  <= '0;
      pipe_q <= '0;
    end else if (adv) begin
      cap_q     <= '{valid: in_valid, mode: mode, acc_clr: acc_clr};
      x_q       <= x_in;
      y_q       <= y_in;
      pipe_q[0] <= '{tag: cap_q, prod: prod};
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end
  rRp_mac_acc #(.PW(PW), .AW(AW)) u_acc (
    .clk    (clock),
    .rst    (reset),
    .adv_i  (adv),
    .tag_i  (pipe_q[DEPTH-1].tag),
    .prod_i (pipe_q[DEPTH-1].prod),
    .valid_o(out_valid),
    .p_o    (p_out),
    .ovf_o  (ovf)
  );
endmodule

// File: tb/tb_rrp_mac_pipe.sv
// tb_rrp_mac_pipe: four DUT configurations on shared stimulus, checked against a program-order MAC model
module tb_rrp_mac_pipe;
  logic        clock = 1'b0;
  logic        reset, in_valid, mode, acc_clr, out_ready;
  logic [11:0] x_in, y_in;
  logic [3:0]  in_ready, out_valid, ovf;
  logic [32:0] p0, p2, p3;
  logic [26:0] p1;
  longint      p_s [4];
  int          aw_i [4] = '{33, 27, 33, 33};
  int          n_chk = 0, n_fail = 0;
  longint      acc_m [4];
  bit          ovf_m [4];
  longint      ep [4][256];
  bit          eo [4][256];
  int          hd [4], tl [4];
  longint      pr, raw, s, pv;
  longint      cv [32];
  bit          co [32];
  int          cc [32];
  int          lat [4];
  int          k;

  always #5 clock = ~clock;

  rrp_mac_pipe #(.WIDTH(4), .RADIX(4), .DEPTH(6), .GUARD(2)) u0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]), .x_in(x_in), .y_in(y_in),
    .mode(mode), .acc_clr(acc_clr), .out_valid(out_valid[0]), .out_ready(out_ready), .p_out(p0), .ovf(ovf[0]));
  rrp_mac_pipe #(.WIDTH(4), .RADIX(4), .DEPTH(6), .GUARD(0)) u1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]), .x_in(x_in), .y_in(y_in),
    .mode(mode), .acc_clr(acc_clr), .out_valid(out_valid[1]), .out_ready(out_ready), .p_out(p1), .ovf(ovf[1]));
  rrp_mac_pipe #(.WIDTH(4), .RADIX(4), .DEPTH(1), .GUARD(2)) u2 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[2]), .x_in(x_in), .y_in(y_in),
    .mode(mode), .acc_clr(acc_clr), .out_valid(out_valid[2]), .out_ready(out_ready), .p_out(p2), .ovf(ovf[2]));
  rrp_mac_pipe #(.WIDTH(4), .RADIX(4), .DEPTH(16), .GUARD(2)) u3 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[3]), .x_in(x_in), .y_in(y_in),
    .mode(mode), .acc_clr(acc_clr), .out_valid(out_valid[3]), .out_ready(out_ready), .p_out(p3), .ovf(ovf[3]));

  always_comb begin
    p_s[0] = longint'($signed(p0));
    p_s[1] = longint'($signed(p1));
    p_s[2] = longint'($signed(p2));
    p_s[3] = longint'($signed(p3));
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint wrap_aw(input longint v, input int aw);
    longint m;
    m = v <<< (64 - aw);
    return m >>> (64 - aw);
  endfunction

  // reference: results computed in acceptance order, compared in retirement order
  always @(negedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (reset) begin
        hd[i] = 0; tl[i] = 0; acc_m[i] = 0; ovf_m[i] = 0;
      end else begin
        if (out_valid[i] && out_ready) begin
          if (hd[i] == tl[i]) check($sformatf("spurious_out%0d", i), out_valid[i], 0);
          else begin
            check($sformatf("p_out%0d", i), p_s[i], ep[i][hd[i] % 256]);
            check($sformatf("ovf%0d", i), ovf[i], eo[i][hd[i] % 256]);
            hd[i]++;
          end
        end
        if (in_valid && in_ready[i]) begin
          pr = longint'($signed(x_in)) * longint'($signed(y_in));
          if (mode) begin
            raw = (acc_clr ? 0 : acc_m[i]) + pr;
            s = wrap_aw(raw, aw_i[i]);
            ovf_m[i] = !acc_clr && (ovf_m[i] || s != raw);
            acc_m[i] = s;
            pv = s;
          end else begin
            pv = pr;
            if (acc_clr) begin acc_m[i] = 0; ovf_m[i] = 0; end
          end
          ep[i][tl[i] % 256] = pv;
          eo[i][tl[i] % 256] = ovf_m[i];
          tl[i]++;
        end
      end
    end
  end

  task automatic send(input logic [11:0] x, input logic [11:0] y, input logic m, input logic c);
    bit ok = 0;
    x_in = x; y_in = y; mode = m; acc_clr = c; in_valid = 1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clock);
      ok = in_ready[0];
      @(posedge clock);
      #1;
    end
    in_valid = 0;
    if (!ok) check("send_timeout", ok, 1);
  endtask

  task automatic collect(input int i, input int n);
    k = 0;
    for (int c = 0; c < 80 && k < n; c++) begin
      @(posedge clock);
      #1;
      if (out_valid[i]) begin cv[k] = p_s[i]; co[k] = ovf[i]; cc[k] = c; k++; end
    end
    check("collect_count", k, n);
  endtask

  initial begin
    reset = 1; in_valid = 0; mode = 0; acc_clr = 0; out_ready = 1; x_in = 0; y_in = 0;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_valid%0d", i), out_valid[i], 0);
      check($sformatf("rst_p%0d", i), p_s[i], 0);
      check($sformatf("rst_ovf%0d", i), ovf[i], 0);
      check($sformatf("rst_ready%0d", i), in_ready[i], 1);
    end
    // single multiply: latency per depth
    x_in = 12'd5; y_in = -12'sd3; mode = 0; acc_clr = 0; in_valid = 1;
    @(posedge clock);
    #1 in_valid = 0;
    lat = '{-1, -1, -1, -1};
    for (int e = 1; e <= 40; e++) begin
      @(posedge clock);
      #1;
      for (int i = 0; i < 4; i++)
        if (lat[i] < 0 && out_valid[i]) begin
          lat[i] = e;
          check($sformatf("mul_p%0d", i), p_s[i], -15);
          check($sformatf("mul_ovf%0d", i), ovf[i], 0);
        end
    end
    check("lat_d6", lat[0], 7);
    check("lat_d6g0", lat[1], 7);
    check("lat_d1", lat[2], 2);
    check("lat_d16", lat[3], 17);
    // MAC sequence
    fork
      begin
        send(12'd2, 12'd3, 1, 1);
        send(12'd4, 12'd5, 1, 0);
        send(-12'sd1, 12'd6, 1, 0);
        send(12'd7, 12'd7, 0, 0);
        send(12'd1, 12'd1, 1, 0);
      end
      collect(0, 5);
    join
    check("mac0", cv[0], 6);
    check("mac1", cv[1], 26);
    check("mac2", cv[2], 20);
    check("mac3", cv[3], 49);
    check("mac4", cv[4], 21);
    check("mac_back2back", cc[4] - cc[0], 4);
    // overflow on the guardless instance
    fork
      begin
        for (int n = 0; n < 16; n++) send(-12'sd2048, -12'sd2048, 1, n == 0);
        send(-12'sd2048, -12'sd2048, 1, 1);
      end
      collect(1, 17);
    join
    for (int n = 0; n < 15; n++) begin
      check($sformatf("ovf_run_p%0d", n + 1), cv[n], 4194304 * (n + 1));
      check($sformatf("ovf_run_flag%0d", n + 1), co[n], 0);
    end
    check("ovf_wrap_p", cv[15], -67108864);
    check("ovf_wrap_flag", co[15], 1);
    check("ovf_clr_p", cv[16], 4194304);
    check("ovf_clr_flag", co[16], 0);
    // random stream with a 10-cycle stall
    fork
      for (int n = 0; n < 20; n++)
        send(12'($urandom), 12'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0);
      begin
        repeat (8) @(posedge clock);
        #2 out_ready = 0;
        repeat (10) begin
          @(negedge clock);
          if (out_valid[0]) check("stall_in_ready", in_ready[0], 0);
        end
        @(posedge clock);
        #2 out_ready = 1;
      end
    join
    repeat (30) @(posedge clock);
    #1;
    // reset with transactions in flight
    for (int n = 0; n < 4; n++) send(12'($urandom), 12'($urandom), 1, n == 0);
    reset = 1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("mid_rst_valid%0d", i), out_valid[i], 0);
      check($sformatf("mid_rst_p%0d", i), p_s[i], 0);
      check($sformatf("mid_rst_ovf%0d", i), ovf[i], 0);
    end
    reset = 0;
    repeat (30) @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) check($sformatf("drain%0d", i), tl[i] - hd[i], 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
